// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: edge-detects request lines, injects a save sequence and
// vectors the PC. Optional nesting is enabled with the IRQ_NEST_EN macro.
module irq_ctrl #(
  parameter int unsigned             NUM_IRQ     = 4,
  parameter int unsigned             PC_WIDTH    = 32,
  parameter int unsigned             INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]     VEC_BASE    = '0,
  parameter int unsigned             VEC_STRIDE  = 2,
  parameter int unsigned             NEST_DEPTH  = 4,
  parameter logic [INSTR_WIDTH-1:0]  INSTR_NOP   = INSTR_WIDTH'(16'h0000),
  parameter logic [INSTR_WIDTH-1:0]  INSTR_SAVE0 = INSTR_WIDTH'(16'h1001),
  parameter logic [INSTR_WIDTH-1:0]  INSTR_SAVE1 = INSTR_WIDTH'(16'h1002),
  parameter logic [INSTR_WIDTH-1:0]  INSTR_SAVE2 = INSTR_WIDTH'(16'h1003)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_IRQ-1:0]     irq,
  input  logic [NUM_IRQ-1:0]     mask,
  input  logic                   hold,
  input  logic                   rti_done,
  output logic                   pc_stop,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   pc_change,
  output logic [PC_WIDTH-1:0]    pc_value,
  output logic [NUM_IRQ-1:0]     ack,
  output logic                   busy,
  output logic [2:0]             depth
);

  localparam int unsigned IdW = $clog2(NUM_IRQ);
`ifdef IRQ_NEST_EN
  localparam bit NestEn = 1'b1;
`else
  localparam bit NestEn = 1'b0;
`endif
  localparam int unsigned StackDepth = NestEn ? NEST_DEPTH : 1;

  typedef enum logic [2:0] {StIdle, StInj0, StInj1, StInj2, StVector, StService} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [IdW-1:0]     stack_q [StackDepth];
  logic [2:0]         depth_q, depth_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic               any_elig;
  logic [IdW-1:0]     sel_id;
  logic [IdW-1:0]     top_id;
  logic               push, pop;
  logic [NUM_IRQ-1:0] clr;

  assign rise     = irq & ~irq_q;
  assign eligible = pend_q & ~mask;
  assign any_elig = |eligible;

  // Lowest index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = IdW'(i);
    end
  end

  always_comb begin
    top_id = '0;
    for (int i = 0; i < StackDepth; i++) begin
      if (int'(depth_q) == i + 1) top_id = stack_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_elig && !hold) begin
          state_d = StInj0;
          push    = 1'b1;
        end
      end
      StInj0:   state_d = StInj1;
      StInj1:   state_d = StInj2;
      StInj2:   state_d = StVector;
      StVector: state_d = StService;
      StService: begin
        // A return takes precedence over a simultaneous preemption.
        if (rti_done) begin
          pop = 1'b1;
          if (depth_q == 3'd1) state_d = StIdle;
        end
`ifdef IRQ_NEST_EN
        else if (any_elig && !hold && (sel_id < top_id) && (depth_q < 3'(StackDepth))) begin
          state_d = StInj0;
          push    = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    depth_d = depth_q;
    if (push)     depth_d = depth_q + 3'd1;
    else if (pop) depth_d = depth_q - 3'd1;
  end

  assign pend_d = (pend_q & ~clr) | rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      irq_q   <= '0;
      pend_q  <= '0;
      depth_q <= '0;
      for (int i = 0; i < StackDepth; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq;
      pend_q  <= pend_d;
      depth_q <= depth_d;
      for (int i = 0; i < StackDepth; i++) begin
        if (push && int'(depth_q) == i) stack_q[i] <= sel_id;
      end
    end
  end

  always_comb begin
    pc_stop     = 1'b0;
    instruction = INSTR_NOP;
    pc_change   = 1'b0;
    pc_value    = '0;
    ack         = '0;
    unique case (state_q)
      StInj0: begin
        pc_stop     = 1'b1;
        instruction = INSTR_SAVE0;
      end
      StInj1: begin
        pc_stop     = 1'b1;
        instruction = INSTR_SAVE1;
      end
      StInj2: begin
        pc_stop     = 1'b1;
        instruction = INSTR_SAVE2;
      end
      StVector: begin
        pc_stop   = 1'b1;
        pc_change = 1'b1;
        pc_value  = VEC_BASE + PC_WIDTH'(top_id) * PC_WIDTH'(VEC_STRIDE);
        ack       = NUM_IRQ'(1) << top_id;
      end
      default: ;
    endcase
  end

  assign clr   = ack;
  assign busy  = (state_q != StIdle);
  assign depth = depth_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl; covers both the default and IRQ_NEST_EN builds.
module tb_irq_ctrl;

  localparam logic [15:0] Nop = 16'h0000;
  localparam logic [15:0] S0  = 16'hA0A1;
  localparam logic [15:0] S1  = 16'hB0B2;
  localparam logic [15:0] S2  = 16'hC0C3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic [3:0]  mask;
  logic        hold;
  logic        rti_done;
  logic        pc_stop;
  logic [15:0] instruction;
  logic        pc_change;
  logic [31:0] pc_value;
  logic [3:0]  ack;
  logic        busy;
  logic [2:0]  depth;

  int errors = 0;
  int checks = 0;

  irq_ctrl #(
    .NUM_IRQ(4), .PC_WIDTH(32), .INSTR_WIDTH(16), .VEC_BASE(32'd0), .VEC_STRIDE(2),
    .NEST_DEPTH(4), .INSTR_NOP(Nop), .INSTR_SAVE0(S0), .INSTR_SAVE1(S1), .INSTR_SAVE2(S2)
  ) dut (
    .clk(clk), .reset(reset), .irq(irq), .mask(mask), .hold(hold), .rti_done(rti_done),
    .pc_stop(pc_stop), .instruction(instruction), .pc_change(pc_change),
    .pc_value(pc_value), .ack(ack), .busy(busy), .depth(depth)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rti();
    rti_done = 1'b1;
    tick();
    rti_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; irq = '0; mask = '0; hold = 1'b0; rti_done = 1'b0;
    #1;
    checks++;
    if ({pc_stop, pc_change, busy, ack, pc_value, instruction, depth} !== {3'b000, 4'h0, 32'h0, Nop, 3'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got stop=%b chg=%b busy=%b ack=%b pc=%h ins=%h depth=%0d",
               pc_stop, pc_change, busy, ack, pc_value, instruction, depth);
    end
    tick(); tick();
    #2 reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_single();
    irq = 4'b0100;
    tick();
    irq = '0;
    checks++;
    if (pc_stop !== 1'b0) begin errors++; $display("FAIL single_pend_stop: %b want 0", pc_stop); end
    tick();
    checks++;
    if ({pc_stop, instruction} !== {1'b1, S0}) begin
      errors++; $display("FAIL single_inj0: stop=%b ins=%h want 1 %h", pc_stop, instruction, S0);
    end
    tick();
    checks++;
    if ({pc_stop, instruction} !== {1'b1, S1}) begin
      errors++; $display("FAIL single_inj1: stop=%b ins=%h want 1 %h", pc_stop, instruction, S1);
    end
    tick();
    checks++;
    if ({pc_stop, instruction, pc_change} !== {1'b1, S2, 1'b0}) begin
      errors++; $display("FAIL single_inj2: stop=%b ins=%h chg=%b", pc_stop, instruction, pc_change);
    end
    tick();
    checks++;
    if ({pc_stop, instruction, pc_change, pc_value, ack} !== {1'b1, Nop, 1'b1, 32'd4, 4'b0100}) begin
      errors++;
      $display("FAIL single_vector: stop=%b ins=%h chg=%b pc=%0d ack=%b want 1 %h 1 4 0100",
               pc_stop, instruction, pc_change, pc_value, ack, Nop);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({busy, pc_stop, pc_change, ack, depth} !== {3'b100, 4'h0, 3'd1}) begin
        errors++;
        $display("FAIL single_service: busy=%b stop=%b chg=%b ack=%b depth=%0d",
                 busy, pc_stop, pc_change, ack, depth);
      end
    end
    pulse_rti();
    checks++;
    if ({busy, depth} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL single_return: busy=%b depth=%0d want 0 0", busy, depth);
    end
  endtask

  task automatic test_priority();
    irq = 4'b1010;
    tick();
    irq = '0;
    tick(); tick(); tick(); tick();
    checks++;
    if ({ack, pc_value} !== {4'b0010, 32'd2}) begin
      errors++; $display("FAIL prio_first: ack=%b pc=%0d want 0010 2", ack, pc_value);
    end
    tick();
    pulse_rti();
    tick();
    checks++;
    if ({pc_stop, instruction} !== {1'b1, S0}) begin
      errors++; $display("FAIL back_to_back_inj0: stop=%b ins=%h want 1 %h", pc_stop, instruction, S0);
    end
    tick(); tick(); tick();
    checks++;
    if ({ack, pc_value, pc_change} !== {4'b1000, 32'd6, 1'b1}) begin
      errors++; $display("FAIL prio_second: ack=%b pc=%0d chg=%b want 1000 6 1", ack, pc_value, pc_change);
    end
    tick();
    pulse_rti();
  endtask

  task automatic test_mask();
    mask = 4'b0001;
    irq  = 4'b0001;
    tick();
    irq = '0;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if ({busy, pc_stop} !== 2'b00) begin
        errors++; $display("FAIL mask_blocked[%0d]: busy=%b stop=%b want 0 0", i, busy, pc_stop);
      end
    end
    mask = '0;
    tick();
    checks++;
    if ({pc_stop, instruction} !== {1'b1, S0}) begin
      errors++; $display("FAIL mask_release_inj0: stop=%b ins=%h want 1 %h", pc_stop, instruction, S0);
    end
    tick(); tick(); tick();
    checks++;
    if ({ack, pc_value} !== {4'b0001, 32'd0}) begin
      errors++; $display("FAIL mask_vector: ack=%b pc=%0d want 0001 0", ack, pc_value);
    end
    tick();
    pulse_rti();
  endtask

  task automatic test_hold();
    hold = 1'b1;
    irq  = 4'b0010;
    tick();
    irq = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pc_stop !== 1'b0) begin errors++; $display("FAIL hold_blocked[%0d]: stop=%b want 0", i, pc_stop); end
      tick();
    end
    checks++;
    if (pc_stop !== 1'b0) begin errors++; $display("FAIL hold_last: stop=%b want 0", pc_stop); end
    hold = 1'b0;
    tick();
    checks++;
    if ({pc_stop, instruction} !== {1'b1, S0}) begin
      errors++; $display("FAIL hold_release_inj0: stop=%b ins=%h want 1 %h", pc_stop, instruction, S0);
    end
    tick(); tick(); tick();
    checks++;
    if (ack !== 4'b0010) begin errors++; $display("FAIL hold_vector: ack=%b want 0010", ack); end
    tick();
    pulse_rti();
  endtask

  task automatic test_reset_mid();
    irq = 4'b0100;
    tick();
    irq = '0;
    tick(); tick();
    checks++;
    if (instruction !== S1) begin errors++; $display("FAIL mid_inj1: ins=%h want %h", instruction, S1); end
    reset = 1'b0;
    #1;
    checks++;
    if ({pc_stop, pc_change, busy, ack, pc_value, instruction, depth} !== {3'b000, 4'h0, 32'h0, Nop, 3'd0}) begin
      errors++;
      $display("FAIL mid_reset_outputs: stop=%b chg=%b busy=%b ack=%b pc=%h ins=%h depth=%0d",
               pc_stop, pc_change, busy, ack, pc_value, instruction, depth);
    end
    #1 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({busy, pc_stop, ack} !== 6'b0) begin
        errors++; $display("FAIL mid_no_entry[%0d]: busy=%b stop=%b ack=%b want 0", i, busy, pc_stop, ack);
      end
    end
  endtask

  task automatic test_nest();
    irq = 4'b0100;
    tick();
    irq = '0;
    tick(); tick(); tick(); tick(); tick();
    irq = 4'b0001;
    tick();
    irq = '0;
`ifdef IRQ_NEST_EN
    tick();
    checks++;
    if ({pc_stop, instruction, depth} !== {1'b1, S0, 3'd2}) begin
      errors++; $display("FAIL nest_preempt: stop=%b ins=%h depth=%0d want 1 %h 2", pc_stop, instruction, depth, S0);
    end
    tick(); tick(); tick();
    checks++;
    if ({ack, pc_value} !== {4'b0001, 32'd0}) begin
      errors++; $display("FAIL nest_vector: ack=%b pc=%0d want 0001 0", ack, pc_value);
    end
    tick();
    pulse_rti();
    checks++;
    if ({busy, depth, pc_stop} !== {1'b1, 3'd1, 1'b0}) begin
      errors++; $display("FAIL nest_pop1: busy=%b depth=%0d stop=%b want 1 1 0", busy, depth, pc_stop);
    end
    tick();
    pulse_rti();
    checks++;
    if ({busy, depth} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL nest_pop2: busy=%b depth=%0d want 0 0", busy, depth);
    end
`else
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({pc_stop, busy, depth} !== {2'b01, 3'd1}) begin
        errors++; $display("FAIL flat_wait[%0d]: stop=%b busy=%b depth=%0d want 0 1 1", i, pc_stop, busy, depth);
      end
    end
    pulse_rti();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flat_return: busy=%b want 0", busy); end
    tick(); tick(); tick(); tick();
    checks++;
    if ({ack, pc_value, depth} !== {4'b0001, 32'd0, 3'd1}) begin
      errors++; $display("FAIL flat_vector: ack=%b pc=%0d depth=%0d want 0001 0 1", ack, pc_value, depth);
    end
    tick();
    pulse_rti();
    checks++;
    if ({busy, depth} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL flat_final: busy=%b depth=%0d want 0 0", busy, depth);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_hold();
    test_reset_mid();
    test_nest();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
